// File: rtl/mem_request_sequencer.sv
// mem_request_sequencer
//
// Request front-end placed directly upstream of memoryModule. Load/store
// requests from the datapath are buffered in a 2-entry FIFO and issued to
// memoryModule one at a time. Each response (read data, write acknowledge or
// timeout error) is handed back on a response port.
//
// Handshake rule for both the req* and rsp* ports: a transfer happens on a
// rising clk edge where valid and ready are both high. The producer keeps
// valid and its payload stable until that edge. Ready is never a function of
// valid on the same port.
//
// Ports:
//   clk, clr              clock; asynchronous active-low reset
//   reqValid/reqReady     request handshake (reqReady = FIFO has room)
//   reqWrite/reqIndirect  request kind: store/load, indirect addressing
//   reqAddr/reqData       request address and store data
//   memCntrl              to memoryModule cntrl: 00 idle, 01 read, 10 write
//   memIndirect/memAddr   to memoryModule isIndirect / addr
//   memDataIn             to memoryModule dataIn
//   memDataOut            from memoryModule dataOut
//   memDataReady          from memoryModule dataReady
//   rspValid/rspReady     response handshake
//   rspData               read data (0 for stores and errors)
//   rspWrite/rspErr       response belongs to a store / memory timed out
//   busy                  transaction in flight or requests queued
//   dbgState              current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module mem_request_sequencer #(
    parameter int ramWidth      = 16,
    parameter int addrSize      = 8,
    parameter int timeoutCycles = 64
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic                reqWrite,
    input  logic                reqIndirect,
    input  logic [addrSize-1:0] reqAddr,
    input  logic [ramWidth-1:0] reqData,
    output logic [1:0]          memCntrl,
    output logic                memIndirect,
    output logic [addrSize-1:0] memAddr,
    output logic [ramWidth-1:0] memDataIn,
    input  logic [ramWidth-1:0] memDataOut,
    input  logic                memDataReady,
    output logic                rspValid,
    input  logic                rspReady,
    output logic [ramWidth-1:0] rspData,
    output logic                rspWrite,
    output logic                rspErr,
    output logic                busy,
    output logic [1:0]          dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } stateT;

    localparam int entryW   = 2 + addrSize + ramWidth;
    localparam int cntWidth = $clog2(timeoutCycles);

    // FIFO entry layout: {write, indirect, addr, data}
    logic [entryW-1:0]   fifoMem [2];
    logic                wrPtr;
    logic                rdPtr;
    logic [1:0]          count;
    logic                push;
    logic                pop;
    logic [entryW-1:0]   head;

    stateT               state;
    logic                cmdWrite;
    logic [cntWidth-1:0] timeoutCnt;

    // Ready looks only at the registered count: a full FIFO refuses a push
    // even on the edge where the head is being popped.
    assign reqReady = (count != 2'd2);
    assign push     = reqValid && reqReady;
    // A dataReady still high from the previous transaction must not be taken
    // as the answer to the next one, so issue waits for it to drop.
    assign pop      = (state == IDLE) && (count != 2'd0) && !memDataReady;
    assign head     = fifoMem[rdPtr];
    assign busy     = (state != IDLE) || (count != 2'd0);
    assign dbgState = state;

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= {reqWrite, reqIndirect, reqAddr, reqData};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wrPtr       <= 1'b0;
            rdPtr       <= 1'b0;
            count       <= 2'd0;
            state       <= IDLE;
            cmdWrite    <= 1'b0;
            timeoutCnt  <= '0;
            memCntrl    <= 2'b00;
            memIndirect <= 1'b0;
            memAddr     <= '0;
            memDataIn   <= '0;
            rspValid    <= 1'b0;
            rspData     <= '0;
            rspWrite    <= 1'b0;
            rspErr      <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        cmdWrite    <= head[entryW-1];
                        memIndirect <= head[entryW-2];
                        memAddr     <= head[ramWidth +: addrSize];
                        memDataIn   <= head[ramWidth-1:0];
                        memCntrl    <= head[entryW-1] ? 2'b10 : 2'b01;
                        timeoutCnt  <= '0;
                        state       <= BUSY;
                    end
                end

                BUSY: begin
                    if (memDataReady) begin
                        rspData  <= cmdWrite ? '0 : memDataOut;
                        rspWrite <= cmdWrite;
                        rspErr   <= 1'b0;
                        rspValid <= 1'b1;
                        memCntrl <= 2'b00;
                        state    <= RESP;
                    end else if (timeoutCnt == cntWidth'(timeoutCycles - 1)) begin
                        rspData  <= '0;
                        rspWrite <= cmdWrite;
                        rspErr   <= 1'b1;
                        rspValid <= 1'b1;
                        memCntrl <= 2'b00;
                        state    <= RESP;
                    end else begin
                        timeoutCnt <= timeoutCnt + cntWidth'(1);
                    end
                end

                RESP: begin
                    memCntrl <= 2'b00;
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        rspErr   <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    memCntrl <= 2'b00;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Self-checking bench for mem_request_sequencer. A behavioural memoryModule
// model answers the sequencer; a reference model computes the expected
// issue order and responses from the requests alone.
module tb_mem_request_sequencer;

    localparam int ramWidth      = 16;
    localparam int addrSize      = 8;
    localparam int timeoutCycles = 64;
    localparam int isw           = 2 + 1 + addrSize + ramWidth;
    localparam int rsw           = 2 + ramWidth;
    localparam int numRand       = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic                reqValid = 1'b0;
    logic                reqReady;
    logic                reqWrite = 1'b0;
    logic                reqIndirect = 1'b0;
    logic [addrSize-1:0] reqAddr = '0;
    logic [ramWidth-1:0] reqData = '0;
    logic [1:0]          memCntrl;
    logic                memIndirect;
    logic [addrSize-1:0] memAddr;
    logic [ramWidth-1:0] memDataIn;
    logic [ramWidth-1:0] memDataOut = '0;
    logic                memDataReady = 1'b0;
    logic                rspValid;
    logic                rspReady = 1'b0;
    logic [ramWidth-1:0] rspData;
    logic                rspWrite;
    logic                rspErr;
    logic                busy;
    logic [1:0]          dbgState;

    mem_request_sequencer #(
        .ramWidth(ramWidth), .addrSize(addrSize), .timeoutCycles(timeoutCycles)
    ) dut (
        .clk(clk), .clr(clr),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqIndirect(reqIndirect), .reqAddr(reqAddr), .reqData(reqData),
        .memCntrl(memCntrl), .memIndirect(memIndirect), .memAddr(memAddr),
        .memDataIn(memDataIn), .memDataOut(memDataOut), .memDataReady(memDataReady),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .rspWrite(rspWrite), .rspErr(rspErr), .busy(busy), .dbgState(dbgState)
    );

    int assertCount = 0;
    int failCount   = 0;

    // ---------------- memoryModule model ----------------
    logic [ramWidth-1:0] modelMem [256];
    logic [ramWidth-1:0] refMem   [256];
    int   latency    = 3;
    bit   randLat    = 1'b0;
    bit   neverReady = 1'b0;
    bit   forceReady = 1'b0;
    int   busCycles  = 0;
    int   curLat     = 0;
    int   unstableCnt = 0;
    logic [isw-1:0] curRec = '0;

    // Scoreboard queues: issued transactions as seen on the mem bus, and
    // responses as accepted on the rsp port.
    logic [isw-1:0] gotIssueQ[$];
    logic [isw-1:0] expIssueQ[$];
    int             gotCycQ[$];
    int             gotLatQ[$];
    logic [rsw-1:0] gotRspQ[$];
    logic [rsw-1:0] expRspQ[$];

    always @(negedge clk) begin
        if (memCntrl != 2'b00) begin
            if (busCycles == 0) begin
                curRec = {memCntrl, memIndirect, memAddr, memDataIn};
                curLat = randLat ? int'($urandom_range(1, 6)) : latency;
            end else if ({memCntrl, memIndirect, memAddr, memDataIn} != curRec) begin
                unstableCnt++;
            end
            busCycles++;
            if (!neverReady && busCycles == curLat) begin
                memDataReady = 1'b1;
                if (memCntrl == 2'b10) begin
                    modelMem[memAddr] = memDataIn;
                    memDataOut = ramWidth'($urandom);
                end else begin
                    memDataOut = modelMem[memAddr];
                end
            end else begin
                memDataReady = forceReady;
                memDataOut   = ramWidth'($urandom);
            end
        end else begin
            if (busCycles != 0) begin
                gotIssueQ.push_back(curRec);
                gotCycQ.push_back(busCycles);
                gotLatQ.push_back(curLat);
            end
            busCycles    = 0;
            memDataReady = forceReady;
            memDataOut   = ramWidth'($urandom);
        end
    end

    always @(negedge clk) begin
        if (clr && rspValid && rspReady) begin
            gotRspQ.push_back({rspErr, rspWrite, rspData});
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic pushReq(input logic w, input logic ind,
                           input logic [addrSize-1:0] a, input logic [ramWidth-1:0] d);
        int waitCyc = 0;
        reqValid = 1'b1; reqWrite = w; reqIndirect = ind; reqAddr = a; reqData = d;
        forever begin
            @(negedge clk);
            if (reqReady) break;
            waitCyc++;
            if (waitCyc > 200) begin
                assertCount++; failCount++;
                $display("FAIL push_wait: reqReady low for %0d cycles, expected accept", waitCyc);
                break;
            end
        end
        @(posedge clk); #1;
        reqValid = 1'b0;
    endtask

    task automatic clearQueues();
        gotIssueQ.delete(); expIssueQ.delete(); gotCycQ.delete(); gotLatQ.delete();
        gotRspQ.delete(); expRspQ.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reqValid = 1'b0; rspReady = 1'b0;
        #2 clr = 1'b0;
        @(negedge clk); #1;
        assertCount++; if (memCntrl !== 2'b00) begin failCount++; $display("FAIL reset_memCntrl: got %b expected 00", memCntrl); end
        assertCount++; if (memIndirect !== 1'b0) begin failCount++; $display("FAIL reset_memIndirect: got %b expected 0", memIndirect); end
        assertCount++; if (memAddr !== '0) begin failCount++; $display("FAIL reset_memAddr: got %0h expected 0", memAddr); end
        assertCount++; if (memDataIn !== '0) begin failCount++; $display("FAIL reset_memDataIn: got %0h expected 0", memDataIn); end
        assertCount++; if (rspValid !== 1'b0) begin failCount++; $display("FAIL reset_rspValid: got %b expected 0", rspValid); end
        assertCount++; if ({rspErr, rspWrite, rspData} !== '0) begin failCount++; $display("FAIL reset_rsp_fields: got %0h expected 0", {rspErr, rspWrite, rspData}); end
        assertCount++; if (busy !== 1'b0) begin failCount++; $display("FAIL reset_busy: got %b expected 0", busy); end
        assertCount++; if (dbgState !== 2'd0) begin failCount++; $display("FAIL reset_dbgState: got %0d expected 0", dbgState); end
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk); #1;
        assertCount++; if (reqReady !== 1'b1) begin failCount++; $display("FAIL reset_reqReady: got %b expected 1", reqReady); end
        @(posedge clk); #1;
        clearQueues();
    endtask

    task automatic test_single_load();
        int n = 0;
        modelMem[8'h12] = 16'hBEEF; latency = 3; rspReady = 1'b0;
        pushReq(1'b0, 1'b0, 8'h12, 16'h0000);
        @(negedge clk); #1;
        assertCount++; if (memCntrl !== 2'b00) begin failCount++; $display("FAIL load_not_early: got %b expected 00", memCntrl); end
        @(negedge clk); #1;
        assertCount++; if ({memCntrl, memAddr} !== {2'b01, 8'h12}) begin failCount++; $display("FAIL load_issue: got %b/%0h expected 01/12", memCntrl, memAddr); end
        while (!rspValid && n < 20) begin @(negedge clk); #1; n++; end
        assertCount++; if (n != 3) begin failCount++; $display("FAIL load_rsp_latency: got %0d expected 3", n); end
        assertCount++; if ({rspValid, rspErr, rspWrite, rspData} !== {3'b100, 16'hBEEF}) begin failCount++; $display("FAIL load_rsp: got v%b e%b w%b %0h expected v1 e0 w0 beef", rspValid, rspErr, rspWrite, rspData); end
        assertCount++; if (memCntrl !== 2'b00) begin failCount++; $display("FAIL load_cntrl_drop: got %b expected 00", memCntrl); end
        assertCount++; if (gotCycQ.size() != 1 || gotCycQ[0] != 3) begin failCount++; $display("FAIL load_bus_cycles: got %0d records expected one of 3 cycles", gotCycQ.size()); end
        @(negedge clk); #1;
        assertCount++; if ({rspValid, rspData} !== {1'b1, 16'hBEEF}) begin failCount++; $display("FAIL load_rsp_hold: got v%b %0h expected v1 beef", rspValid, rspData); end
        @(posedge clk); #1; rspReady = 1'b1;
        @(posedge clk); #1; rspReady = 1'b0;
        @(negedge clk); #1;
        assertCount++; if ({rspValid, busy} !== 2'b00) begin failCount++; $display("FAIL load_rsp_release: got v%b busy%b expected 00", rspValid, busy); end
        @(posedge clk); #1;
        clearQueues();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        latency = 2; rspReady = 1'b1;
        pushReq(1'b1, 1'b0, 8'h34, 16'h00A5);
        pushReq(1'b0, 1'b0, 8'h34, 16'h1234);
        while (gotRspQ.size() < 2 && n < 100) begin @(negedge clk); #1; n++; end
        assertCount++; if (gotRspQ.size() != 2 || gotIssueQ.size() != 2) begin failCount++; $display("FAIL b2b_count: got %0d rsp %0d issue expected 2 2", gotRspQ.size(), gotIssueQ.size()); end
        if (gotRspQ.size() >= 2 && gotIssueQ.size() >= 2) begin
            assertCount++; if (gotIssueQ[0] !== {2'b10, 1'b0, 8'h34, 16'h00A5}) begin failCount++; $display("FAIL b2b_store_issue: got %0h expected store 34<-00a5", gotIssueQ[0]); end
            assertCount++; if (gotIssueQ[1][isw-1 -: 2+1+addrSize] !== {2'b01, 1'b0, 8'h34}) begin failCount++; $display("FAIL b2b_load_issue: got %0h expected load 34", gotIssueQ[1]); end
            assertCount++; if (gotCycQ[0] != 2 || gotCycQ[1] != 2) begin failCount++; $display("FAIL b2b_idle_gap: got %0d/%0d cycles expected 2/2", gotCycQ[0], gotCycQ[1]); end
            assertCount++; if (gotRspQ[0] !== {1'b0, 1'b1, 16'h0000}) begin failCount++; $display("FAIL b2b_store_rsp: got %0h expected w1 data 0", gotRspQ[0]); end
            assertCount++; if (gotRspQ[1] !== {1'b0, 1'b0, 16'h00A5}) begin failCount++; $display("FAIL b2b_load_rsp: got %0h expected 00a5", gotRspQ[1]); end
        end
        @(posedge clk); #1;
        clearQueues();
    endtask

    task automatic test_stale_ready();
        int n = 0;
        forceReady = 1'b1; rspReady = 1'b1; latency = 2;
        pushReq(1'b0, 1'b1, 8'h56, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            assertCount++; if ({memCntrl, busy} !== 3'b001) begin failCount++; $display("FAIL stale_guard: got cntrl %b busy %b expected 00 1", memCntrl, busy); end
        end
        @(posedge clk); #1; forceReady = 1'b0;
        @(negedge clk); #1;
        assertCount++; if (memCntrl !== 2'b00) begin failCount++; $display("FAIL stale_still_idle: got %b expected 00", memCntrl); end
        @(negedge clk); #1;
        assertCount++; if ({memCntrl, memIndirect, memAddr} !== {2'b01, 1'b1, 8'h56}) begin failCount++; $display("FAIL stale_issue: got %b %b %0h expected 01 1 56", memCntrl, memIndirect, memAddr); end
        while (gotRspQ.size() < 1 && n < 50) begin @(negedge clk); #1; n++; end
        assertCount++; if (gotRspQ.size() != 1 || gotRspQ[0] !== {2'b00, modelMem[8'h56]}) begin failCount++; $display("FAIL stale_rsp: got %0d rsp expected one load of %0h", gotRspQ.size(), modelMem[8'h56]); end
        @(posedge clk); #1;
        clearQueues();
    endtask

    task automatic test_fifo_full();
        int n = 0;
        modelMem[8'h21] = 16'hA001; modelMem[8'h22] = 16'hB002; modelMem[8'h23] = 16'hC003;
        forceReady = 1'b1; rspReady = 1'b0; latency = 2;
        pushReq(1'b0, 1'b0, 8'h21, 16'h0);
        pushReq(1'b0, 1'b0, 8'h22, 16'h0);
        reqValid = 1'b1; reqWrite = 1'b0; reqIndirect = 1'b0; reqAddr = 8'h23; reqData = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            assertCount++; if ({reqReady, busy} !== 2'b01) begin failCount++; $display("FAIL full_refuse: got ready %b busy %b expected 0 1", reqReady, busy); end
        end
        @(posedge clk); #1; forceReady = 1'b0;
        @(negedge clk); #1;
        assertCount++; if (reqReady !== 1'b0) begin failCount++; $display("FAIL full_no_lookahead: got %b expected 0", reqReady); end
        @(posedge clk); #1;
        @(negedge clk); #1;
        assertCount++; if ({reqReady, memCntrl, memAddr} !== {1'b1, 2'b01, 8'h21}) begin failCount++; $display("FAIL full_first_issue: got %b %b %0h expected 1 01 21", reqReady, memCntrl, memAddr); end
        @(posedge clk); #1; reqValid = 1'b0;
        while (!rspValid && n < 20) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            assertCount++; if ({rspValid, memCntrl} !== 3'b100) begin failCount++; $display("FAIL full_rsp_hold: got v%b cntrl %b expected 1 00", rspValid, memCntrl); end
        end
        @(posedge clk); #1; rspReady = 1'b1;
        n = 0;
        while (gotRspQ.size() < 3 && n < 100) begin @(negedge clk); #1; n++; end
        assertCount++; if (gotRspQ.size() != 3 || gotIssueQ.size() != 3) begin failCount++; $display("FAIL full_count: got %0d rsp %0d issue expected 3 3", gotRspQ.size(), gotIssueQ.size()); end
        if (gotRspQ.size() >= 3 && gotIssueQ.size() >= 3) begin
            assertCount++; if ({gotIssueQ[0][ramWidth +: addrSize], gotIssueQ[1][ramWidth +: addrSize], gotIssueQ[2][ramWidth +: addrSize]} !== 24'h212223) begin failCount++; $display("FAIL full_order: got %0h %0h %0h expected 21 22 23", gotIssueQ[0][ramWidth +: addrSize], gotIssueQ[1][ramWidth +: addrSize], gotIssueQ[2][ramWidth +: addrSize]); end
            assertCount++; if ({gotRspQ[0][ramWidth-1:0], gotRspQ[1][ramWidth-1:0], gotRspQ[2][ramWidth-1:0]} !== 48'hA001_B002_C003) begin failCount++; $display("FAIL full_rsp_order: got %0h %0h %0h expected a001 b002 c003", gotRspQ[0], gotRspQ[1], gotRspQ[2]); end
        end
        @(posedge clk); #1;
        clearQueues();
    endtask

    task automatic test_timeout();
        int n = 0;
        neverReady = 1'b1; rspReady = 1'b1;
        pushReq(1'b0, 1'b0, 8'h77, 16'h0);
        while (gotRspQ.size() < 1 && n < 200) begin @(negedge clk); #1; n++; end
        assertCount++; if (gotRspQ.size() != 1 || gotCycQ.size() != 1) begin failCount++; $display("FAIL timeout_seen: got %0d rsp expected 1", gotRspQ.size()); end
        if (gotRspQ.size() >= 1 && gotCycQ.size() >= 1) begin
            assertCount++; if (gotCycQ[0] != timeoutCycles) begin failCount++; $display("FAIL timeout_cycles: got %0d expected %0d", gotCycQ[0], timeoutCycles); end
            assertCount++; if ({gotRspQ[0][rsw-1], gotRspQ[0][ramWidth-1:0]} !== {1'b1, 16'h0}) begin failCount++; $display("FAIL timeout_rsp: got %0h expected err 1 data 0", gotRspQ[0]); end
        end
        @(posedge clk); #1;
        neverReady = 1'b0; latency = 1; modelMem[8'h78] = 16'h5A5A;
        pushReq(1'b0, 1'b0, 8'h78, 16'h0);
        n = 0;
        while (gotRspQ.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
        assertCount++; if (gotRspQ.size() != 2 || gotRspQ[1] !== {2'b00, 16'h5A5A}) begin failCount++; $display("FAIL timeout_recover: got %0d rsp expected second load 5a5a", gotRspQ.size()); end
        @(posedge clk); #1;
        clearQueues();
    endtask

    task automatic test_reset_mid_busy();
        int n = 0;
        int active = 0;
        neverReady = 1'b1; rspReady = 1'b0;
        pushReq(1'b0, 1'b0, 8'h9A, 16'h0);
        pushReq(1'b1, 1'b0, 8'h9B, 16'h1111);
        pushReq(1'b0, 1'b0, 8'h9C, 16'h0);
        @(negedge clk); #1;
        assertCount++; if ({memCntrl, reqReady} !== 3'b010) begin failCount++; $display("FAIL rst_pre: got cntrl %b ready %b expected 01 0", memCntrl, reqReady); end
        clr = 1'b0;
        #1;
        assertCount++; if ({memCntrl, rspValid, busy} !== 4'b0000) begin failCount++; $display("FAIL rst_async: got cntrl %b v%b busy%b expected 00 0 0", memCntrl, rspValid, busy); end
        @(posedge clk); #1;
        clr = 1'b1; neverReady = 1'b0; latency = 2;
        @(negedge clk); #1;
        assertCount++; if ({reqReady, busy} !== 2'b10) begin failCount++; $display("FAIL rst_release: got ready %b busy %b expected 1 0", reqReady, busy); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (memCntrl != 2'b00) active++;
        end
        assertCount++; if (active != 0) begin failCount++; $display("FAIL rst_fifo_empty: got %0d issue cycles expected 0", active); end
        @(posedge clk); #1;
        clearQueues();
        modelMem[8'h9D] = 16'h7E57;
        pushReq(1'b0, 1'b0, 8'h9D, 16'h0);
        rspReady = 1'b1;
        while (gotRspQ.size() < 1 && n < 50) begin @(negedge clk); #1; n++; end
        assertCount++; if (gotRspQ.size() != 1 || gotRspQ[0] !== {2'b00, 16'h7E57}) begin failCount++; $display("FAIL rst_after_load: got %0d rsp expected one load 7e57", gotRspQ.size()); end
        @(posedge clk); #1;
        clearQueues();
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            modelMem[i] = ramWidth'($urandom);
            refMem[i]   = modelMem[i];
        end
        randLat = 1'b1; neverReady = 1'b0; forceReady = 1'b0; unstableCnt = 0;
        clearQueues();
        fork
            begin
                logic                w;
                logic                ind;
                logic [addrSize-1:0] a;
                logic [ramWidth-1:0] d;
                for (int i = 0; i < numRand; i++) begin
                    w   = 1'($urandom_range(0, 1));
                    ind = 1'($urandom_range(0, 1));
                    a   = addrSize'($urandom_range(0, 15));
                    d   = ramWidth'($urandom);
                    expIssueQ.push_back({w ? 2'b10 : 2'b01, ind, a, d});
                    if (w) begin
                        expRspQ.push_back({1'b0, 1'b1, {ramWidth{1'b0}}});
                        refMem[a] = d;
                    end else begin
                        expRspQ.push_back({1'b0, 1'b0, refMem[a]});
                    end
                    pushReq(w, ind, a, d);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                int guard = 0;
                while (gotRspQ.size() < numRand && guard < 3000) begin
                    rspReady = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    guard++;
                end
            end
        join
        rspReady = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        assertCount++; if (gotRspQ.size() != numRand || gotIssueQ.size() != numRand) begin failCount++; $display("FAIL rand_count: got %0d rsp %0d issue expected %0d", gotRspQ.size(), gotIssueQ.size(), numRand); end
        for (int i = 0; i < numRand; i++) begin
            if (i < gotIssueQ.size()) begin
                assertCount++; if (gotIssueQ[i] !== expIssueQ[i]) begin failCount++; $display("FAIL rand_issue[%0d]: got %0h expected %0h", i, gotIssueQ[i], expIssueQ[i]); end
                assertCount++; if (gotCycQ[i] != gotLatQ[i]) begin failCount++; $display("FAIL rand_bus_cycles[%0d]: got %0d expected %0d", i, gotCycQ[i], gotLatQ[i]); end
            end
            if (i < gotRspQ.size()) begin
                assertCount++; if (gotRspQ[i] !== expRspQ[i]) begin failCount++; $display("FAIL rand_rsp[%0d]: got %0h expected %0h", i, gotRspQ[i], expRspQ[i]); end
            end
        end
        assertCount++; if (unstableCnt != 0) begin failCount++; $display("FAIL rand_bus_stable: got %0d changes expected 0", unstableCnt); end
        randLat = 1'b0;
        clearQueues();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            modelMem[i] = ramWidth'(i * 37 + 5);
            refMem[i]   = modelMem[i];
        end
        test_reset();
        test_single_load();
        test_back_to_back();
        test_stale_ready();
        test_fifo_full();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
